// File: rtl/ddr_ws_pkg.sv
// Shared definitions for the Wishbone-to-MIG line bridge: MIG command codes,
// FSM state encoding and beat/counter sizing helpers.
package ddr_ws_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_ACK  = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    function automatic int beats_of(input int ws_w, input int app_w);
        return ws_w / app_w;
    endfunction

    // Counters must hold the value BEATS itself (the "done" marker).
    function automatic int cnt_w(input int beats);
        return $clog2(beats + 1);
    endfunction

    function automatic int idx_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/ddr_ws_bridge.sv
// Wishbone line slave to MIG app_* bridge: one line access becomes BEATS MIG
// transfers. Optional read timeout enabled by defining DDR_WS_TIMEOUT_EN.
module ddr_ws_bridge
    import ddr_ws_pkg::*;
#(
    parameter int WS_DATA_W      = 512,
    parameter int APP_DATA_W     = 256,
    parameter int DQ_W           = 32,
    parameter int WS_ADDR_W      = 32,
    parameter int APP_ADDR_W     = 28,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WS_ADDR_W-1:0]    ws_addr,
    input  logic [WS_DATA_W-1:0]    ws_din,
    input  logic [WS_DATA_W/8-1:0]  ws_sel,
    input  logic                    ws_cyc,
    input  logic                    ws_stb,
    input  logic                    ws_we,
    output logic                    ws_ack,
    output logic                    ws_err,
    output logic [WS_DATA_W-1:0]    ws_dout,
    input  logic                    init_calib_complete,
    output logic [APP_ADDR_W-1:0]   app_addr,
    output logic [2:0]              app_cmd,
    output logic                    app_en,
    input  logic                    app_rdy,
    output logic [APP_DATA_W-1:0]   app_wdf_data,
    output logic [APP_DATA_W/8-1:0] app_wdf_mask,
    output logic                    app_wdf_wren,
    output logic                    app_wdf_end,
    input  logic                    app_wdf_rdy,
    input  logic [APP_DATA_W-1:0]   app_rd_data,
    input  logic                    app_rd_data_valid,
    output logic [2:0]              dbg_state
);

    localparam int BEATS = beats_of(WS_DATA_W, APP_DATA_W);
    localparam int CW    = cnt_w(BEATS);
    localparam int IW    = idx_w(BEATS);
    localparam int OFF   = $clog2(WS_DATA_W / 8);
    localparam int LAW   = WS_ADDR_W - OFF;
    localparam int MW    = APP_DATA_W / 8;
    localparam int AW    = LAW + CW + 16;
    localparam logic [CW-1:0] BEATS_C = CW'(BEATS);

    state_e                           state;
    logic [LAW-1:0]                   line_addr;
    logic [BEATS-1:0][APP_DATA_W-1:0] wr_line;
    logic [BEATS-1:0][MW-1:0]         wr_mask;
    logic [BEATS-1:0][APP_DATA_W-1:0] rd_line;
    logic [CW-1:0]                    cmd_cnt, dat_cnt, cmd_nxt, dat_nxt;
    logic [IW-1:0]                    dat_idx;
    logic                             cmd_fire, wdf_fire, rd_fire, accept, to_hit;

    assign accept   = ws_cyc && ws_stb && init_calib_complete;
    assign app_en   = ((state == ST_WR) || (state == ST_RD)) && (cmd_cnt < BEATS_C);
    assign app_wdf_wren = (state == ST_WR) && (dat_cnt < BEATS_C);
    assign app_wdf_end  = app_wdf_wren;
    assign app_cmd  = (state == ST_WR) ? CMD_WRITE : CMD_READ;

    assign cmd_fire = app_en && app_rdy;
    assign wdf_fire = app_wdf_wren && app_wdf_rdy;
    // Beats arriving outside RD (after reset or timeout) are dropped here.
    assign rd_fire  = (state == ST_RD) && app_rd_data_valid && (dat_cnt < BEATS_C);

    assign cmd_nxt  = cmd_cnt + CW'(cmd_fire);
    assign dat_nxt  = dat_cnt + CW'(wdf_fire || rd_fire);
    assign dat_idx  = (dat_cnt < BEATS_C) ? dat_cnt[IW-1:0] : '0;

    assign app_addr = APP_ADDR_W'((AW'(line_addr) * AW'(BEATS) + AW'(cmd_cnt))
                                  * AW'(APP_DATA_W / DQ_W));

    // One-hot beat select for the write-data path (beat 0 = line LSBs).
    logic [BEATS-1:0][APP_DATA_W-1:0] data_pick;
    logic [BEATS-1:0][MW-1:0]         mask_pick;

    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        assign data_pick[b] = (dat_idx == IW'(b)) ? wr_line[b] : '0;
        assign mask_pick[b] = (dat_idx == IW'(b)) ? wr_mask[b] : '0;
    end

    always_comb begin
        app_wdf_data = '0;
        app_wdf_mask = '0;
        for (int b = 0; b < BEATS; b++) begin
            app_wdf_data = app_wdf_data | data_pick[b];
            app_wdf_mask = app_wdf_mask | mask_pick[b];
        end
    end

`ifdef DDR_WS_TIMEOUT_EN
    logic [31:0] to_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            to_cnt <= '0;
        else if (state != ST_RD)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 32'd1;
    end

    assign to_hit = (state == ST_RD) && (to_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign ws_err = (state == ST_ERR);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign to_hit = 1'b0;
    assign ws_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            line_addr <= '0;
            wr_line   <= '0;
            wr_mask   <= '0;
            rd_line   <= '0;
            cmd_cnt   <= '0;
            dat_cnt   <= '0;
        end else begin
            if (rd_fire)
                rd_line[dat_idx] <= app_rd_data;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        line_addr <= ws_addr[WS_ADDR_W-1:OFF];
                        wr_line   <= ws_din;
                        wr_mask   <= ~ws_sel;
                        cmd_cnt   <= '0;
                        dat_cnt   <= '0;
                        state     <= ws_we ? ST_WR : ST_RD;
                    end
                end
                ST_WR: begin
                    cmd_cnt <= cmd_nxt;
                    dat_cnt <= dat_nxt;
                    if (cmd_nxt == BEATS_C && dat_nxt == BEATS_C)
                        state <= ST_ACK;
                end
                ST_RD: begin
                    cmd_cnt <= cmd_nxt;
                    dat_cnt <= dat_nxt;
                    if (dat_nxt == BEATS_C)
                        state <= ST_ACK;
                    else if (to_hit)
                        state <= ST_ERR;
                end
                ST_ACK:  state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ws_ack    = (state == ST_ACK);
    assign ws_dout   = rd_line;
    assign dbg_state = state;

    logic unused_addr;
    assign unused_addr = ^ws_addr[OFF-1:0];

endmodule

// File: tb/tb_ddr_ws_bridge.sv
// Scoreboard bench for ddr_ws_bridge: expected MIG commands, write beats and
// Wishbone responses are queued at stimulus time and checked by a monitor.
module tb_ddr_ws_bridge;
    import ddr_ws_pkg::*;

    localparam int WSW = 512;
    localparam int APW = 256;
    localparam int AAW = 28;
    localparam int TOC = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [31:0]      ws_addr = '0;
    logic [WSW-1:0]   ws_din = '0;
    logic [WSW/8-1:0] ws_sel = '0;
    logic             ws_cyc = 1'b0, ws_stb = 1'b0, ws_we = 1'b0;
    logic             ws_ack, ws_err;
    logic [WSW-1:0]   ws_dout;
    logic             init_calib_complete = 1'b1;
    logic [AAW-1:0]   app_addr;
    logic [2:0]       app_cmd;
    logic             app_en, app_rdy = 1'b1;
    logic [APW-1:0]   app_wdf_data;
    logic [APW/8-1:0] app_wdf_mask;
    logic             app_wdf_wren, app_wdf_end, app_wdf_rdy = 1'b1;
    logic [APW-1:0]   app_rd_data = '0;
    logic             app_rd_data_valid = 1'b0;
    logic [2:0]       dbg_state;

    ddr_ws_bridge #(.TIMEOUT_CYCLES(TOC)) dut (
        .clk(clk), .rst(rst), .ws_addr(ws_addr), .ws_din(ws_din), .ws_sel(ws_sel),
        .ws_cyc(ws_cyc), .ws_stb(ws_stb), .ws_we(ws_we), .ws_ack(ws_ack),
        .ws_err(ws_err), .ws_dout(ws_dout), .init_calib_complete(init_calib_complete),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AAW-1:0] addr; logic [2:0] cmd; } cmd_t;
    typedef struct { logic [APW-1:0] d; logic [APW/8-1:0] m; } dat_t;
    typedef struct { bit err; bit rd; logic [WSW-1:0] dout; } rsp_t;

    cmd_t cmd_q[$];
    dat_t dat_q[$];
    rsp_t rsp_q[$];

    int cyc = 0, last_evt = 0, rsp_cnt = 0, err_due = 0;
    int checks = 0, errors = 0;
    bit rdy_tog = 1'b0, wdf_block = 1'b0;

    localparam logic [APW-1:0] RB0 = {8{32'h0B0B_0000}};
    localparam logic [APW-1:0] RB1 = {8{32'h1B1B_1111}};
    localparam logic [APW-1:0] RB2 = {8{32'h2B2B_2222}};
    localparam logic [APW-1:0] RB3 = {8{32'h3C3C_3333}};
    localparam logic [APW-1:0] RB4 = {8{32'h4D4D_4444}};
    localparam logic [APW-1:0] W0  = {8{32'hC0DE_0001}};
    localparam logic [APW-1:0] W1  = {8{32'hBEEF_0002}};

    task automatic checki(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic checkw(input string name, input logic [WSW-1:0] act, input logic [WSW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [AAW-1:0] a, input logic [2:0] c);
        cmd_t e;
        e.addr = a; e.cmd = c;
        cmd_q.push_back(e);
    endtask

    task automatic push_dat(input logic [APW-1:0] d, input logic [APW/8-1:0] m);
        dat_t e;
        e.d = d; e.m = m;
        dat_q.push_back(e);
    endtask

    task automatic push_rsp(input bit err, input bit rd, input logic [WSW-1:0] dout);
        rsp_t e;
        e.err = err; e.rd = rd; e.dout = dout;
        rsp_q.push_back(e);
    endtask

    task automatic issue(input bit we, input logic [31:0] a, input logic [WSW-1:0] din,
                         input logic [WSW/8-1:0] sel);
        ws_addr = a; ws_din = din; ws_sel = sel; ws_we = we;
        ws_cyc = 1'b1; ws_stb = 1'b1;
    endtask

    // Wait (bounded) until n responses have been seen, then drop the strobe.
    task automatic wait_rsp(input int n, input string name);
        int k = 0;
        while (rsp_cnt < n && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        checki(name, int'(rsp_cnt >= n), 1);
        ws_cyc = 1'b0; ws_stb = 1'b0;
    endtask

    task automatic rd_beat(input logic [APW-1:0] d);
        app_rd_data = d; app_rd_data_valid = 1'b1;
        step();
        app_rd_data_valid = 1'b0;
    endtask

    // MIG ready model
    initial forever begin
        @(posedge clk);
        #2;
        app_rdy     = rdy_tog ? ~app_rdy : 1'b1;
        app_wdf_rdy = ~wdf_block;
    end

    // Monitor / scoreboard
    initial begin
        cmd_t c;
        dat_t d;
        rsp_t r;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                if (app_en && app_rdy) begin
                    checki("cmd_expected", int'(cmd_q.size() != 0), 1);
                    if (cmd_q.size() != 0) begin
                        c = cmd_q.pop_front();
                        checki("cmd_addr", int'(app_addr), int'(c.addr));
                        checki("cmd_code", int'(app_cmd), int'(c.cmd));
                    end
                    last_evt = cyc;
                end
                if (app_wdf_wren && app_wdf_rdy) begin
                    checki("wdf_expected", int'(dat_q.size() != 0), 1);
                    if (dat_q.size() != 0) begin
                        d = dat_q.pop_front();
                        checkw("wdf_data", WSW'(app_wdf_data), WSW'(d.d));
                        checki("wdf_mask", int'(app_wdf_mask), int'(d.m));
                        checki("wdf_end", int'(app_wdf_end), 1);
                    end
                    last_evt = cyc;
                end
                if (app_rd_data_valid && dbg_state == 3'd2)
                    last_evt = cyc;
                if (ws_ack || ws_err) begin
                    checki("rsp_expected", int'(rsp_q.size() != 0), 1);
                    if (rsp_q.size() != 0) begin
                        r = rsp_q.pop_front();
                        checki("rsp_err", int'(ws_err), int'(r.err));
                        checki("rsp_ack", int'(ws_ack), int'(!r.err));
                        checki("rsp_state", int'(dbg_state), r.err ? 4 : 3);
                        if (r.err) checki("err_latency", cyc, err_due);
                        else       checki("ack_latency", cyc, last_evt + 1);
                        if (r.rd)  checkw("rd_dout", ws_dout, r.dout);
                    end
                    rsp_cnt++;
                end
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        repeat (3) step();
        // reset state
        checki("rst_ack", int'(ws_ack), 0);
        checki("rst_err", int'(ws_err), 0);
        checki("rst_en", int'(app_en), 0);
        checki("rst_wren", int'(app_wdf_wren), 0);
        checki("rst_addr", int'(app_addr), 0);
        checki("rst_state", int'(dbg_state), 0);
        checkw("rst_dout", ws_dout, '0);
        rst = 1'b1;
        step();

        // 1: full write, MIG always ready
        push_cmd(28'h10, CMD_WRITE); push_cmd(28'h18, CMD_WRITE);
        push_dat({32{8'hAA}}, '0);   push_dat({32{8'hAA}}, '0);
        push_rsp(1'b0, 1'b0, '0);
        issue(1'b1, 32'h40, {64{8'hAA}}, '1);
        wait_rsp(1, "wr1_done");
        step();
        checki("wr1_idle", int'(dbg_state), 0);

        // 2: read with 3-cycle gap between beats
        push_cmd(28'h10, CMD_READ); push_cmd(28'h18, CMD_READ);
        push_rsp(1'b0, 1'b1, {RB1, RB0});
        issue(1'b0, 32'h40, '0, '0);
        step();
        checki("rd2_state_rd", int'(dbg_state), 2);
        step(); step();
        rd_beat(RB0);
        step(); step();
        rd_beat(RB1);
        wait_rsp(2, "rd2_done");
        step();
        checki("rd2_state_idle", int'(dbg_state), 0);
        checkw("rd2_dout_held", ws_dout, {RB1, RB0});

        // 3: write with data stalled and command ready toggling
        push_cmd(28'h20, CMD_WRITE); push_cmd(28'h28, CMD_WRITE);
        push_dat(W0, 32'h0000_0001); push_dat(W1, 32'hF0F0_F0F0);
        push_rsp(1'b0, 1'b0, '0);
        rdy_tog = 1'b1; wdf_block = 1'b1;
        issue(1'b1, 32'h80, {W1, W0}, 64'h0F0F_0F0F_FFFF_FFFE);
        repeat (6) step();
        checki("wr3_cmds_first", cmd_q.size(), 0);
        checki("wr3_data_held", dat_q.size(), 2);
        checki("wr3_still_wr", int'(dbg_state), 1);
        wdf_block = 1'b0;
        wait_rsp(3, "wr3_done");
        rdy_tog = 1'b0;
        step();

        // 4: calibration gating
        init_calib_complete = 1'b0;
        issue(1'b1, 32'h0, {64{8'h5A}}, '1);
        for (int i = 0; i < 20; i++) begin
            step();
            checki("cal_no_en", int'(app_en), 0);
            checki("cal_idle", int'(dbg_state), 0);
        end
        push_cmd(28'h0, CMD_WRITE); push_cmd(28'h8, CMD_WRITE);
        push_dat({32{8'h5A}}, '0);  push_dat({32{8'h5A}}, '0);
        push_rsp(1'b0, 1'b0, '0);
        init_calib_complete = 1'b1;
        wait_rsp(4, "cal_done");
        step();

        // 5: reset mid-read after one beat
        push_cmd(28'h30, CMD_READ); push_cmd(28'h38, CMD_READ);
        issue(1'b0, 32'hC0, '0, '0);
        step(); step();
        rd_beat(RB2);
        rst = 1'b0;
        #1;
        checki("mid_rst_state", int'(dbg_state), 0);
        checki("mid_rst_en", int'(app_en), 0);
        checki("mid_rst_ack", int'(ws_ack), 0);
        checkw("mid_rst_dout", ws_dout, '0);
        ws_cyc = 1'b0; ws_stb = 1'b0;
        step();
        rst = 1'b1;
        step();
        rd_beat({8{32'hDEAD_BEEF}});
        checkw("trail_dout", ws_dout, '0);
        checki("trail_idle", int'(dbg_state), 0);
        push_cmd(28'h10, CMD_READ); push_cmd(28'h18, CMD_READ);
        push_rsp(1'b0, 1'b1, {RB4, RB3});
        issue(1'b0, 32'h40, '0, '0);
        step();
        rd_beat(RB3);
        rd_beat(RB4);
        wait_rsp(5, "rd5_done");
        step();

`ifdef DDR_WS_TIMEOUT_EN
        // 6: read timeout, no data returned
        push_cmd(28'h40, CMD_READ); push_cmd(28'h48, CMD_READ);
        push_rsp(1'b1, 1'b0, '0);
        err_due = cyc + TOC + 2;
        issue(1'b0, 32'h100, '0, '0);
        wait_rsp(6, "to_done");
        step();
        rd_beat(RB0);
        checkw("to_late_beat", ws_dout, {RB4, RB3});
        checki("to_idle", int'(dbg_state), 0);
`endif

        repeat (4) step();
        checki("end_cmd_q", cmd_q.size(), 0);
        checki("end_dat_q", dat_q.size(), 0);
        checki("end_rsp_q", rsp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
